// File: rtl/axi_lite_scratchpad_pro.sv
// AXI4-Lite scratchpad RAM: flop storage, per-channel request FIFOs,
// byte strobes, SLVERR for addresses past the end of the array, and
// write-first data on a same-cycle, same-word read/write collision.

// Small request FIFO; head is visible the cycle after the push.
module axi_lite_scratchpad_pro_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_full
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_data  = r_mem[r_rdPtr];
  assign o_valid = (r_count != '0);
  assign o_full  = (r_count == FULL_CNT);

  // Entry storage needs no reset: the count decides what is valid.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wrPtr] <= i_data;
  end

  // Pointer and occupancy bookkeeping; push+pop together keeps the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wrPtr <= nextPtr(r_wrPtr);
      if (i_pop)  r_rdPtr <= nextPtr(r_rdPtr);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module axi_lite_scratchpad_pro #(
  parameter int DATA_W        = 32,
  parameter int DEPTH         = 16,
  parameter int ADDR_W        = $clog2(DEPTH * DATA_W / 8) + 1,
  parameter int RD_FIFO_DEPTH = 2,
  parameter int WR_FIFO_DEPTH = 2,
  localparam int STRB_W       = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] i_axi_awaddr,
  input  logic              i_axi_awvalid,
  output logic              o_axi_awready,
  input  logic [DATA_W-1:0] i_axi_wdata,
  input  logic [STRB_W-1:0] i_axi_wstrb,
  input  logic              i_axi_wvalid,
  output logic              o_axi_wready,
  output logic [1:0]        o_axi_bresp,
  output logic              o_axi_bvalid,
  input  logic              i_axi_bready,
  input  logic [ADDR_W-1:0] i_axi_araddr,
  input  logic              i_axi_arvalid,
  output logic              o_axi_arready,
  output logic [DATA_W-1:0] o_axi_rdata,
  output logic [1:0]        o_axi_rresp,
  output logic              o_axi_rvalid,
  input  logic              i_axi_rready
);
  localparam int OFF_W = $clog2(STRB_W);
  localparam int IDX_W = ADDR_W - OFF_W;
  localparam int LOG_D = $clog2(DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic              r_readyEn;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_bvalid;
  logic [1:0]        r_bresp;
  logic              r_rvalid;
  logic [1:0]        r_rresp;
  logic [DATA_W-1:0] r_rdata;

  logic              w_awFull, w_wFull, w_arFull;
  logic              w_awValid, w_wValid, w_arValid;
  logic [IDX_W-1:0]  w_awIdx, w_arIdx;
  logic [DATA_W-1:0] w_wData;
  logic [STRB_W-1:0] w_wStrb;
  logic              w_awInRange, w_arInRange;
  logic              w_wrCommit, w_rdIssue;
  logic [DATA_W-1:0] w_wrMerged;
  logic [DATA_W-1:0] w_rdWord;
  logic              w_unusedOffset;

  // Byte offset bits are deliberately dropped: accesses align down to a word.
  assign w_unusedOffset = ^{i_axi_awaddr[OFF_W-1:0], i_axi_araddr[OFF_W-1:0]};

  assign o_axi_awready = r_readyEn & ~w_awFull;
  assign o_axi_wready  = r_readyEn & ~w_wFull;
  assign o_axi_arready = r_readyEn & ~w_arFull;
  assign o_axi_bvalid  = r_bvalid;
  assign o_axi_bresp   = r_bresp;
  assign o_axi_rvalid  = r_rvalid;
  assign o_axi_rresp   = r_rresp;
  assign o_axi_rdata   = r_rdata;

  // Readies stay low through reset and rise on the first edge after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_readyEn <= 1'b0;
    else        r_readyEn <= 1'b1;
  end

  axi_lite_scratchpad_pro_fifo #(.WIDTH(IDX_W), .DEPTH(WR_FIFO_DEPTH)) u_awFifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (i_axi_awvalid & o_axi_awready),
    .i_data  (i_axi_awaddr[ADDR_W-1:OFF_W]),
    .i_pop   (w_wrCommit),
    .o_data  (w_awIdx),
    .o_valid (w_awValid),
    .o_full  (w_awFull)
  );

  axi_lite_scratchpad_pro_fifo #(.WIDTH(DATA_W + STRB_W), .DEPTH(WR_FIFO_DEPTH)) u_wFifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (i_axi_wvalid & o_axi_wready),
    .i_data  ({i_axi_wstrb, i_axi_wdata}),
    .i_pop   (w_wrCommit),
    .o_data  ({w_wStrb, w_wData}),
    .o_valid (w_wValid),
    .o_full  (w_wFull)
  );

  axi_lite_scratchpad_pro_fifo #(.WIDTH(IDX_W), .DEPTH(RD_FIFO_DEPTH)) u_arFifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (i_axi_arvalid & o_axi_arready),
    .i_data  (i_axi_araddr[ADDR_W-1:OFF_W]),
    .i_pop   (w_rdIssue),
    .o_data  (w_arIdx),
    .o_valid (w_arValid),
    .o_full  (w_arFull)
  );

  assign w_awInRange = ~|w_awIdx[IDX_W-1:LOG_D];
  assign w_arInRange = ~|w_arIdx[IDX_W-1:LOG_D];
  assign w_wrCommit  = w_awValid & w_wValid & (~r_bvalid | i_axi_bready);
  assign w_rdIssue   = w_arValid & (~r_rvalid | i_axi_rready);

  // New word for the write target: strobed lanes from W, the rest kept.
  always_comb begin
    w_wrMerged = r_mem[w_awIdx[LOG_D-1:0]];
    for (int i = 0; i < STRB_W; i++) begin
      if (w_wStrb[i]) w_wrMerged[i*8 +: 8] = w_wData[i*8 +: 8];
    end
  end

  // Read word, taking the merged write data when both hit the same word.
  always_comb begin
    w_rdWord = '0;
    if (w_arInRange) begin
      if (w_wrCommit && w_awInRange && (w_awIdx == w_arIdx)) w_rdWord = w_wrMerged;
      else                                                  w_rdWord = r_mem[w_arIdx[LOG_D-1:0]];
    end
  end

  // Storage array, cleared by reset; out-of-range writes are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else if (w_wrCommit && w_awInRange) begin
      r_mem[w_awIdx[LOG_D-1:0]] <= w_wrMerged;
    end
  end

  // Write response register: loads on commit, holds until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bvalid <= 1'b0;
      r_bresp  <= RESP_OKAY;
    end else if (w_wrCommit) begin
      r_bvalid <= 1'b1;
      r_bresp  <= w_awInRange ? RESP_OKAY : RESP_SLVERR;
    end else if (i_axi_bready) begin
      r_bvalid <= 1'b0;
    end
  end

  // Read response register: loads on issue, holds until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_rresp  <= RESP_OKAY;
      r_rdata  <= '0;
    end else if (w_rdIssue) begin
      r_rvalid <= 1'b1;
      r_rresp  <= w_arInRange ? RESP_OKAY : RESP_SLVERR;
      r_rdata  <= w_rdWord;
    end else if (i_axi_rready) begin
      r_rvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axi_lite_scratchpad_pro.sv
// Directed bench for axi_lite_scratchpad_pro with the default 32x16 build.
module tb_axi_lite_scratchpad_pro;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 7;
  localparam int STRB_W = 4;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] i_axi_awaddr = '0;
  logic              i_axi_awvalid = 1'b0;
  logic              o_axi_awready;
  logic [DATA_W-1:0] i_axi_wdata = '0;
  logic [STRB_W-1:0] i_axi_wstrb = '0;
  logic              i_axi_wvalid = 1'b0;
  logic              o_axi_wready;
  logic [1:0]        o_axi_bresp;
  logic              o_axi_bvalid;
  logic              i_axi_bready = 1'b0;
  logic [ADDR_W-1:0] i_axi_araddr = '0;
  logic              i_axi_arvalid = 1'b0;
  logic              o_axi_arready;
  logic [DATA_W-1:0] o_axi_rdata;
  logic [1:0]        o_axi_rresp;
  logic              o_axi_rvalid;
  logic              i_axi_rready = 1'b0;

  int nCompared   = 0;
  int nMismatched = 0;

  axi_lite_scratchpad_pro #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .RD_FIFO_DEPTH(2), .WR_FIFO_DEPTH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_axi_awaddr(i_axi_awaddr), .i_axi_awvalid(i_axi_awvalid), .o_axi_awready(o_axi_awready),
    .i_axi_wdata(i_axi_wdata), .i_axi_wstrb(i_axi_wstrb), .i_axi_wvalid(i_axi_wvalid),
    .o_axi_wready(o_axi_wready), .o_axi_bresp(o_axi_bresp), .o_axi_bvalid(o_axi_bvalid),
    .i_axi_bready(i_axi_bready), .i_axi_araddr(i_axi_araddr), .i_axi_arvalid(i_axi_arvalid),
    .o_axi_arready(o_axi_arready), .o_axi_rdata(o_axi_rdata), .o_axi_rresp(o_axi_rresp),
    .o_axi_rvalid(o_axi_rvalid), .i_axi_rready(i_axi_rready)
  );

  always #5 clk = ~clk;

  // Advance one cycle and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic awv, input logic [ADDR_W-1:0] awa,
                               input logic wv, input logic [DATA_W-1:0] wd,
                               input logic [STRB_W-1:0] ws,
                               input logic arv, input logic [ADDR_W-1:0] ara);
    i_axi_awvalid = awv;
    i_axi_awaddr  = awa;
    i_axi_wvalid  = wv;
    i_axi_wdata   = wd;
    i_axi_wstrb   = ws;
    i_axi_arvalid = arv;
    i_axi_araddr  = ara;
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic checkReadies(input string tag, input logic expected);
    checkOutput({tag, " awready"}, 64'(o_axi_awready), 64'(expected));
    checkOutput({tag, " wready"},  64'(o_axi_wready),  64'(expected));
    checkOutput({tag, " arready"}, 64'(o_axi_arready), 64'(expected));
  endtask

  // Single write with AW and W together; bvalid expected exactly 2 cycles later.
  task automatic writeOne(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                          input logic [STRB_W-1:0] strb, input logic [1:0] expResp, input string tag);
    i_axi_bready = 1'b1;
    applyStimulus(1'b1, addr, 1'b1, data, strb, 1'b0, '0);
    checkOutput({tag, " awready"}, 64'(o_axi_awready), 64'd1);
    checkOutput({tag, " wready"},  64'(o_axi_wready),  64'd1);
    tick();
    idle();
    checkOutput({tag, " bvalid N+1"}, 64'(o_axi_bvalid), 64'd0);
    tick();
    checkOutput({tag, " bvalid N+2"}, 64'(o_axi_bvalid), 64'd1);
    checkOutput({tag, " bresp"}, 64'(o_axi_bresp), 64'(expResp));
    tick();
    checkOutput({tag, " bvalid drop"}, 64'(o_axi_bvalid), 64'd0);
  endtask

  // Single read; rvalid expected exactly 2 cycles after the AR handshake.
  task automatic readOne(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] expData,
                         input logic [1:0] expResp, input string tag);
    i_axi_rready = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1, addr);
    checkOutput({tag, " arready"}, 64'(o_axi_arready), 64'd1);
    tick();
    idle();
    checkOutput({tag, " rvalid N+1"}, 64'(o_axi_rvalid), 64'd0);
    tick();
    checkOutput({tag, " rvalid N+2"}, 64'(o_axi_rvalid), 64'd1);
    checkOutput({tag, " rdata"}, 64'(o_axi_rdata), 64'(expData));
    checkOutput({tag, " rresp"}, 64'(o_axi_rresp), 64'(expResp));
    tick();
    checkOutput({tag, " rvalid drop"}, 64'(o_axi_rvalid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    idle();
    repeat (3) tick();
    checkReadies("reset", 1'b0);
    checkOutput("reset bvalid", 64'(o_axi_bvalid), 64'd0);
    checkOutput("reset rvalid", 64'(o_axi_rvalid), 64'd0);
    checkOutput("reset bresp",  64'(o_axi_bresp),  64'd0);
    checkOutput("reset rresp",  64'(o_axi_rresp),  64'd0);
    checkOutput("reset rdata",  64'(o_axi_rdata),  64'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("post-reset awready before edge", 64'(o_axi_awready), 64'd0);
    tick();
    checkReadies("post-reset edge", 1'b1);

    // Back-to-back writes then pipelined reads
    writeOne(7'h00, 32'hDEADBEEF, 4'hF, OKAY, "wr 0x0");
    writeOne(7'h04, 32'h12345678, 4'hF, OKAY, "wr 0x4");
    i_axi_rready = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1, 7'h00);
    checkOutput("b2b ar0 arready", 64'(o_axi_arready), 64'd1);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1, 7'h04);
    checkOutput("b2b ar1 arready", 64'(o_axi_arready), 64'd1);
    checkOutput("b2b rvalid N+1", 64'(o_axi_rvalid), 64'd0);
    tick();
    idle();
    checkOutput("b2b rvalid 0", 64'(o_axi_rvalid), 64'd1);
    checkOutput("b2b rdata 0", 64'(o_axi_rdata), 64'hDEADBEEF);
    checkOutput("b2b rresp 0", 64'(o_axi_rresp), 64'(OKAY));
    tick();
    checkOutput("b2b rvalid 1", 64'(o_axi_rvalid), 64'd1);
    checkOutput("b2b rdata 1", 64'(o_axi_rdata), 64'h12345678);
    tick();
    checkOutput("b2b rvalid drop", 64'(o_axi_rvalid), 64'd0);

    // Byte strobes
    writeOne(7'h08, 32'hAABBCCDD, 4'hF, OKAY, "wr 0x8 full");
    writeOne(7'h08, 32'h11223344, 4'b0101, OKAY, "wr 0x8 strb");
    readOne(7'h08, 32'hAA22CC44, OKAY, "rd 0x8 strb");

    // Out of range, zero strobe, unaligned address
    writeOne(7'h40, 32'hFFFFFFFF, 4'hF, SLVERR, "wr oor");
    readOne(7'h40, 32'h0, SLVERR, "rd oor");
    readOne(7'h00, 32'hDEADBEEF, OKAY, "rd 0x0 after oor");
    writeOne(7'h04, 32'hFFFFFFFF, 4'h0, OKAY, "wr strb0");
    readOne(7'h07, 32'h12345678, OKAY, "rd unaligned 0x7");

    // Backpressure: 4 writes and 4 reads with responses stalled
    i_axi_bready = 1'b0;
    i_axi_rready = 1'b0;
    applyStimulus(1'b1, 7'h10, 1'b1, 32'hA0A0A0A0, 4'hF, 1'b1, 7'h00);
    checkReadies("bp req0", 1'b1);
    tick();
    applyStimulus(1'b1, 7'h44, 1'b1, 32'h0BADF00D, 4'hF, 1'b1, 7'h48);
    checkReadies("bp req1", 1'b1);
    tick();
    applyStimulus(1'b1, 7'h14, 1'b1, 32'hC3C3C3C3, 4'hF, 1'b1, 7'h08);
    checkReadies("bp req2", 1'b1);
    checkOutput("bp first bvalid", 64'(o_axi_bvalid), 64'd1);
    checkOutput("bp first rvalid", 64'(o_axi_rvalid), 64'd1);
    tick();
    applyStimulus(1'b1, 7'h18, 1'b1, 32'h5A5A5A5A, 4'hF, 1'b1, 7'h04);
    for (int k = 0; k < 3; k++) begin
      checkReadies($sformatf("bp stall %0d", k), 1'b0);
      checkOutput($sformatf("bp stall %0d bvalid", k), 64'(o_axi_bvalid), 64'd1);
      checkOutput($sformatf("bp stall %0d bresp", k), 64'(o_axi_bresp), 64'(OKAY));
      checkOutput($sformatf("bp stall %0d rvalid", k), 64'(o_axi_rvalid), 64'd1);
      checkOutput($sformatf("bp stall %0d rdata", k), 64'(o_axi_rdata), 64'hDEADBEEF);
      checkOutput($sformatf("bp stall %0d rresp", k), 64'(o_axi_rresp), 64'(OKAY));
      tick();
    end
    i_axi_bready = 1'b1;
    i_axi_rready = 1'b1;
    checkReadies("bp release", 1'b0);
    checkOutput("bp resp0 bresp", 64'(o_axi_bresp), 64'(OKAY));
    checkOutput("bp resp0 rdata", 64'(o_axi_rdata), 64'hDEADBEEF);
    tick();
    checkReadies("bp req3 accept", 1'b1);
    checkOutput("bp resp1 bvalid", 64'(o_axi_bvalid), 64'd1);
    checkOutput("bp resp1 bresp", 64'(o_axi_bresp), 64'(SLVERR));
    checkOutput("bp resp1 rvalid", 64'(o_axi_rvalid), 64'd1);
    checkOutput("bp resp1 rdata", 64'(o_axi_rdata), 64'h0);
    checkOutput("bp resp1 rresp", 64'(o_axi_rresp), 64'(SLVERR));
    tick();
    idle();
    checkOutput("bp resp2 bvalid", 64'(o_axi_bvalid), 64'd1);
    checkOutput("bp resp2 bresp", 64'(o_axi_bresp), 64'(OKAY));
    checkOutput("bp resp2 rdata", 64'(o_axi_rdata), 64'hAA22CC44);
    checkOutput("bp resp2 rresp", 64'(o_axi_rresp), 64'(OKAY));
    tick();
    checkOutput("bp resp3 bvalid", 64'(o_axi_bvalid), 64'd1);
    checkOutput("bp resp3 bresp", 64'(o_axi_bresp), 64'(OKAY));
    checkOutput("bp resp3 rvalid", 64'(o_axi_rvalid), 64'd1);
    checkOutput("bp resp3 rdata", 64'(o_axi_rdata), 64'h12345678);
    tick();
    checkOutput("bp drain bvalid", 64'(o_axi_bvalid), 64'd0);
    checkOutput("bp drain rvalid", 64'(o_axi_rvalid), 64'd0);
    readOne(7'h10, 32'hA0A0A0A0, OKAY, "rd bp 0x10");
    readOne(7'h18, 32'h5A5A5A5A, OKAY, "rd bp 0x18");

    // W beats ahead of AW
    i_axi_bready = 1'b1;
    applyStimulus(1'b0, '0, 1'b1, 32'h0000CAFE, 4'hF, 1'b0, '0);
    checkOutput("wfirst w0 wready", 64'(o_axi_wready), 64'd1);
    tick();
    applyStimulus(1'b0, '0, 1'b1, 32'h0000BEEF, 4'hF, 1'b0, '0);
    checkOutput("wfirst w1 wready", 64'(o_axi_wready), 64'd1);
    tick();
    idle();
    checkOutput("wfirst wready full", 64'(o_axi_wready), 64'd0);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("wfirst wait %0d bvalid", k), 64'(o_axi_bvalid), 64'd0);
      tick();
    end
    applyStimulus(1'b1, 7'h20, 1'b0, '0, '0, 1'b0, '0);
    checkOutput("wfirst aw0 awready", 64'(o_axi_awready), 64'd1);
    tick();
    applyStimulus(1'b1, 7'h24, 1'b0, '0, '0, 1'b0, '0);
    checkOutput("wfirst aw1 awready", 64'(o_axi_awready), 64'd1);
    checkOutput("wfirst bvalid N+1", 64'(o_axi_bvalid), 64'd0);
    tick();
    idle();
    checkOutput("wfirst bvalid N+2", 64'(o_axi_bvalid), 64'd1);
    checkOutput("wfirst bresp 0", 64'(o_axi_bresp), 64'(OKAY));
    tick();
    checkOutput("wfirst bvalid 2nd", 64'(o_axi_bvalid), 64'd1);
    tick();
    checkOutput("wfirst bvalid drop", 64'(o_axi_bvalid), 64'd0);
    readOne(7'h20, 32'h0000CAFE, OKAY, "rd wfirst 0x20");
    readOne(7'h24, 32'h0000BEEF, OKAY, "rd wfirst 0x24");

    // Same-cycle write commit and read to word 0
    writeOne(7'h00, 32'h12345600, 4'hF, OKAY, "wr coll setup");
    i_axi_bready = 1'b1;
    i_axi_rready = 1'b1;
    applyStimulus(1'b1, 7'h00, 1'b1, 32'h000000FF, 4'h1, 1'b1, 7'h00);
    checkReadies("coll req", 1'b1);
    tick();
    idle();
    tick();
    checkOutput("coll bvalid", 64'(o_axi_bvalid), 64'd1);
    checkOutput("coll bresp", 64'(o_axi_bresp), 64'(OKAY));
    checkOutput("coll rvalid", 64'(o_axi_rvalid), 64'd1);
    checkOutput("coll rdata", 64'(o_axi_rdata), 64'h123456FF);
    tick();
    readOne(7'h00, 32'h123456FF, OKAY, "rd after coll");

    // Reset while a write response is pending
    i_axi_bready = 1'b0;
    applyStimulus(1'b1, 7'h04, 1'b1, 32'h00000055, 4'hF, 1'b0, '0);
    tick();
    idle();
    tick();
    checkOutput("midrst bvalid before", 64'(o_axi_bvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst bvalid", 64'(o_axi_bvalid), 64'd0);
    checkOutput("midrst awready", 64'(o_axi_awready), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checkReadies("midrst release", 1'b1);
    checkOutput("midrst bvalid after", 64'(o_axi_bvalid), 64'd0);
    for (int k = 0; k < DEPTH; k++) begin
      readOne(7'(k * 4), 32'h0, OKAY, $sformatf("rd cleared word %0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
